jht_update_ctrl: RTL

- Sequences the jump history table's single replace/write port.
- Accepts up to two executed-jump updates per cycle from the dual-issue EXE stage and buffers them in a small FIFO.
- Drains one update per cycle to the table.
- Runs the table-clear sweep after reset and on pipeline flush requests.

---
 rtl/jht_update_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/jht_update_ctrl.sv
// Jump history table update controller.
// Buffers up to two executed-jump updates per cycle, drains one per cycle to
// the table's single write port, and runs the table-clear sweep after reset
// and after every flush.
module jht_update_ctrl #(
  parameter int SET_NUM    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int INDEX_BITS = $clog2(SET_NUM)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          flush,
  input  logic                          upd0_valid,
  input  logic [31:0]                   upd0_pc,
  input  logic [31:0]                   upd0_dest,
  input  logic                          upd1_valid,
  input  logic [31:0]                   upd1_pc,
  input  logic [31:0]                   upd1_dest,
  output logic                          tbl_we,
  output logic [31:0]                   tbl_pc,
  output logic [31:0]                   tbl_dest,
  output logic                          tbl_clr,
  output logic [INDEX_BITS-1:0]         tbl_clr_index,
  output logic                          init_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   drop_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(SET_NUM - 1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] dest;
  } upd_t;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [INDEX_BITS-1:0] idx, idx_nxt;

  upd_t                  mem [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;

  logic                  run;
  logic                  enq_en;
  logic                  coal;
  logic                  need0, need1;
  logic [1:0]            n_need, n_acc, n_drop;
  logic [CW:0]           free;
  upd_t                  e0, e1, head;
  logic [16:0]           drop_sum;

  // FSM state and sweep index register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_INIT;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next state: sweep SET_NUM sets, then run; flush restarts the sweep
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_INIT, S_FLUSH: begin
        if (flush) begin
          idx_nxt = '0;
        end else if (idx == LAST_IDX) begin
          state_nxt = S_RUN;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + INDEX_BITS'(1);
        end
      end
      S_RUN: begin
        if (flush) begin
          state_nxt = S_FLUSH;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_INIT;
        idx_nxt   = '0;
      end
    endcase
  end

  // Table-facing outputs are derived from registered state only
  always_comb begin
    run           = (state == S_RUN);
    tbl_clr       = !run;
    tbl_clr_index = idx;
    init_done     = run;
    head          = mem[rd_ptr];
    tbl_we        = run && (count != '0);
    tbl_pc        = tbl_we ? head.pc   : 32'd0;
    tbl_dest      = tbl_we ? head.dest : 32'd0;
    fifo_count    = count;
  end

  // Enqueue decision: coalesce same-pc pairs, keep program order, drop overflow
  always_comb begin
    enq_en = run && !flush;
    coal   = upd0_valid && upd1_valid && (upd0_pc == upd1_pc);
    need0  = upd0_valid;
    need1  = upd1_valid && !coal;
    n_need = {1'b0, need0} + {1'b0, need1};
    free   = (CW+1)'(FIFO_DEPTH) - {1'b0, count} + {{CW{1'b0}}, tbl_we};

    // Youngest surviving entry goes second; a coalesced pair keeps pipe-1's dest
    e0 = upd0_valid ? '{pc: upd0_pc, dest: (coal ? upd1_dest : upd0_dest)}
                    : '{pc: upd1_pc, dest: upd1_dest};
    e1 = '{pc: upd1_pc, dest: upd1_dest};

    n_acc = 2'd0;
    if (enq_en) begin
      if (free >= (CW+1)'(2))      n_acc = n_need;
      else if (free == (CW+1)'(1)) n_acc = (n_need != 2'd0) ? 2'd1 : 2'd0;
      else                         n_acc = 2'd0;
    end
    n_drop   = enq_en ? (n_need - n_acc) : 2'd0;
    drop_sum = {1'b0, drop_cnt} + {15'd0, n_drop};
  end

  // FIFO pointers, occupancy and drop counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (tbl_we) rd_ptr <= rd_ptr + PW'(1);
        wr_ptr <= wr_ptr + PW'(n_acc);
        count  <= count + CW'(n_acc) - CW'(tbl_we);
      end
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // FIFO storage: up to two writes per cycle at consecutive slots
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (n_acc != 2'd0) mem[wr_ptr] <= e0;
      if (n_acc == 2'd2) mem[wr_ptr + PW'(1)] <= e1;
    end
  end

endmodule
